// File: rtl/rx_pkt_word_framer.sv
// Frames received packets as 64-bit words (header, packed payload, status)
// into a small FIFO read through a valid/ready master port.
// Ports: clk, rstn (async, active-low)
//   in : pkt_header_valid_strobe, pkt_len[15:0], pkt_rate[3:0]
//   in : byte_in[7:0], byte_in_strobe, fcs_in_strobe, fcs_ok, m_ready
//   out: m_word[63:0], m_valid, m_last, pkt_dropped, fifo_count[FIFO_AW:0]
module rx_pkt_word_framer #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pkt_header_valid_strobe,
    input  logic [15:0]      pkt_len,
    input  logic [3:0]       pkt_rate,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_strobe,
    input  logic             fcs_in_strobe,
    input  logic             fcs_ok,
    output logic [63:0]      m_word,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             pkt_dropped,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LP_LIM  = (FIFO_AW+1)'(DEPTH - 2);
    localparam logic [FIFO_AW:0] LP_FULL = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_WAIT, S_STATUS, S_ABORT
    } state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_len, r_cnt, r_sn;
    logic [3:0]         r_rate;
    logic [63:0]        r_word;
    logic               r_trunc, r_fcs_seen, r_fcs_ok, r_dropped;

    logic [64:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr, r_rd;
    logic [FIFO_AW:0]   r_count;

    logic        w_push, w_push_last, w_pop, w_space, w_full;
    logic [63:0] w_push_word, w_word_next;
    logic        w_latch, w_start, w_take, w_flush, w_trunc_set;
    logic        w_sn_inc, w_drop, w_last_byte, w_fcs_any, w_hdr;

    assign w_hdr       = pkt_header_valid_strobe;
    assign w_space     = r_count <= LP_LIM;
    assign w_full      = r_count == LP_FULL;
    assign w_pop       = (r_count != '0) && m_ready;
    assign w_last_byte = (r_cnt + 16'd1) == r_len;
    assign w_fcs_any   = r_fcs_seen | fcs_in_strobe;
    // Byte lane chosen by the low bits of the byte counter (little-endian).
    assign w_word_next = r_word | (64'(byte_in) << {r_cnt[2:0], 3'b000});

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_push_word = '0;
        w_push_last = 1'b0;
        w_latch     = 1'b0;
        w_start     = 1'b0;
        w_take      = 1'b0;
        w_flush     = 1'b0;
        w_trunc_set = 1'b0;
        w_sn_inc    = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    w_next  = S_HDR;
                end
            end
            S_HDR: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    w_next  = S_ABORT;
                end else if (w_space) begin
                    w_push      = 1'b1;
                    w_push_word = {16'h0, r_sn, 12'h0, r_rate, r_len};
                    w_start     = 1'b1;
                    w_next      = (r_len == 16'd0) ? S_WAIT : S_DATA;
                end else begin
                    w_drop = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    w_next  = S_ABORT;
                end else if (byte_in_strobe && r_cnt < r_len) begin
                    w_take = 1'b1;
                    if (r_cnt[2:0] == 3'd7 || w_last_byte) begin
                        w_flush = 1'b1;
                        if (w_space) begin
                            w_push      = 1'b1;
                            w_push_word = w_word_next;
                        end else begin
                            w_trunc_set = 1'b1;
                        end
                    end
                    // An FCS verdict already in hand skips WAIT.
                    if (w_last_byte) begin
                        w_next = w_fcs_any ? S_STATUS : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    w_next  = S_ABORT;
                end else if (w_fcs_any) begin
                    w_next = S_STATUS;
                end
            end
            S_STATUS: begin
                if (w_hdr) begin
                    w_latch = 1'b1;
                    w_next  = S_ABORT;
                end else if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_last = 1'b1;
                    w_push_word = {16'h0, r_sn, 29'h0, 1'b0, r_trunc, r_fcs_ok};
                    w_sn_inc    = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_ABORT: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_last = 1'b1;
                    w_push_word = {16'h0, r_sn, 29'h0, 3'b100};
                    w_sn_inc    = 1'b1;
                    w_next      = S_HDR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_rate    <= '0;
            r_sn      <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_trunc   <= 1'b0;
            r_fcs_seen <= 1'b0;
            r_fcs_ok  <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dropped <= w_drop;
            if (w_latch) begin
                r_len  <= pkt_len;
                r_rate <= pkt_rate;
            end
            if (w_sn_inc) begin
                r_sn <= r_sn + 16'd1;
            end
            if (w_start) begin
                r_cnt      <= '0;
                r_word     <= '0;
                r_trunc    <= 1'b0;
                r_fcs_seen <= 1'b0;
                r_fcs_ok   <= 1'b0;
            end else begin
                if (w_take) begin
                    r_cnt  <= r_cnt + 16'd1;
                    r_word <= w_flush ? '0 : w_word_next;
                end
                if (w_trunc_set) begin
                    r_trunc <= 1'b1;
                end
                if (fcs_in_strobe &&
                    (r_state == S_DATA || r_state == S_WAIT)) begin
                    r_fcs_seen <= 1'b1;
                    r_fcs_ok   <= fcs_ok;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_push_last, w_push_word};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Gate the head so the outputs read 0 while the FIFO is empty.
    assign m_valid     = r_count != '0;
    assign m_word      = m_valid ? r_mem[r_rd][63:0] : '0;
    assign m_last      = m_valid ? r_mem[r_rd][64] : 1'b0;
    assign fifo_count  = r_count;
    assign pkt_dropped = r_dropped;

endmodule
